// File: rtl/result_bcd_converter.sv
// Iterative shift-and-add-3 binary-to-BCD converter; W cycles per conversion.
// Optional signed input handling is enabled by defining BCD_SIGN_EN.
module result_bcd_converter #(
    parameter int unsigned W      = 17,
    parameter int unsigned DIGITS = 6
) (
    input  logic                  board_clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg
);

    localparam int unsigned WR    = 4*DIGITS + W;
    localparam int unsigned CNT_W = $clog2(W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WR-1:0]        work_q, work_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic [W-1:0]         mag;
    logic [WR-1:0]        adj;
    logic [WR-1:0]        shifted;
`ifdef BCD_SIGN_EN
    logic                 sign_q, sign_d;
    logic                 neg_q, neg_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
`ifdef BCD_SIGN_EN
        sign_d  = sign_q;
        neg_d   = neg_q;
        mag     = bin[W-1] ? (~bin + 1'b1) : bin;
`else
        mag     = bin;
`endif

        // Correct every BCD nibble >= 5 before the shift doubles it.
        adj = work_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            logic [3:0] nib;
            nib = work_q[W + 4*i +: 4];
            if (nib >= 4'd5) begin
                adj[W + 4*i +: 4] = nib + 4'd3;
            end
        end
        shifted = {adj[WR-2:0], 1'b0};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    work_d  = {{(4*DIGITS){1'b0}}, mag};
                    cnt_d   = CNT_W'(W);
                    busy_d  = 1'b1;
`ifdef BCD_SIGN_EN
                    sign_d  = bin[W-1];
`endif
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = shifted[WR-1:W];
`ifdef BCD_SIGN_EN
                    neg_d   = sign_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
`ifdef BCD_SIGN_EN
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
`ifdef BCD_SIGN_EN
            sign_q  <= sign_d;
            neg_q   <= neg_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
`ifdef BCD_SIGN_EN
    assign neg  = neg_q;
`else
    assign neg  = 1'b0;
`endif

endmodule
